// File: rtl/counter_checker.sv
// Reference-model checker for a free-running WIDTH-bit counter with carry output.
// Tracks the expected count, flags count/carry mismatches, counts verified wraps and aborts on stalls.
module counter_checker #(
  parameter int WIDTH         = 8,
  parameter int WRAPS_TO_PASS = 1,
  parameter int TIMEOUT       = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enb,
  input  logic [WIDTH-1:0] count,
  input  logic             carryout,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [15:0]      err_count,
  output logic [15:0]      wrap_count,
  output logic             timeout,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]    STALL_LIM = SW'(TIMEOUT);
  localparam logic [15:0]      WRAP_LIM  = 16'(WRAPS_TO_PASS);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [SW-1:0] sat_inc_stall(input logic [SW-1:0] v);
    return (v == STALL_LIM) ? v : v + SW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic e);
    return v + WIDTH'(e);
  endfunction

  state_t        state;
  logic [SW-1:0] stall;

  logic          count_ok;
  logic          exp_max;
  logic          carry_ok;
  logic          mismatch;
  logic          wrap_hit;
  logic [15:0]   wrap_next;
  logic [SW-1:0] stall_next;

  always_comb begin
    count_ok   = (count == expected);
    exp_max    = (expected == ALL_ONES);
    carry_ok   = (carryout == (enb & exp_max));
    mismatch   = ~(count_ok & carry_ok);
    wrap_hit   = count_ok & carry_ok & enb & exp_max;
    wrap_next  = wrap_hit ? sat_inc16(wrap_count) : wrap_count;
    stall_next = enb ? '0 : sat_inc_stall(stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      expected   <= '0;
      err        <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
      timeout    <= 1'b0;
      stall      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= CHECK;
            expected   <= step(count, enb);
            err        <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            timeout    <= 1'b0;
            stall      <= '0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err       <= 1'b1;
            err_count <= sat_inc16(err_count);
          end
          // On a count mismatch, resync to the observed value so one glitch is one error.
          expected   <= count_ok ? step(expected, enb) : step(count, enb);
          wrap_count <= wrap_next;
          stall      <= stall_next;
          // A completing wrap wins over a stall abort on the same edge.
          if (wrap_hit && (wrap_next == WRAP_LIM)) begin
            state <= DONE;
          end else if (!enb && (stall_next == STALL_LIM)) begin
            timeout <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);
  assign pass = (state == DONE) & ~err & ~timeout;

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width under check.
REQ-002 SHALL have parameter WRAPS_TO_PASS, default 1, correct wraps required to finish.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max consecutive CHECK cycles with enb=0 before abort.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; arms checking.
REQ-007 enb  in  1  counter enable, as driven to the counter under check.
REQ-008 count  in  WIDTH  counter output under check.
REQ-009 carryout  in  1  counter carry output under check.
REQ-010 expected  out  WIDTH  model's expected count for the current cycle.
REQ-011 err  out  1  sticky; any mismatch since last start.
REQ-012 err_count  out  16  mismatch count; saturates at 16'hFFFF.
REQ-013 wrap_count  out  16  correctly checked wraps; saturates at 16'hFFFF.
REQ-014 timeout  out  1  sticky; stall abort occurred.
REQ-015 done  out  1  high in DONE.
REQ-016 pass  out  1  high in DONE when err=0 and timeout=0.

Function
REQ-017 Counter contract: count advances by 1 mod 2^WIDTH on each clk edge with enb=1; carryout = enb AND (count == all-ones), same cycle.
REQ-018 States: IDLE, CHECK, DONE.
REQ-019 IDLE: start=1 -> CHECK; expected <= count + enb (mod 2^WIDTH); clear err, err_count, wrap_count, timeout, stall counter; no compare that cycle.
REQ-020 CHECK, each cycle: count_ok = (count == expected); carry_ok = (carryout == (enb AND expected == all-ones)).
REQ-021 CHECK: count_ok=0 or carry_ok=0 -> err <= 1, err_count += 1 (at most 1 per cycle even if both fail).
REQ-022 CHECK: count_ok=1 -> expected <= expected + enb; count_ok=0 -> expected <= count + enb (resync, no cascading errors).
REQ-023 CHECK: count_ok=1, carry_ok=1, enb=1, expected all-ones -> wrap_count += 1.
REQ-024 CHECK -> DONE on the edge where wrap_count reaches WRAPS_TO_PASS.
REQ-025 CHECK stall counter: increments on enb=0, clears on enb=1; at TIMEOUT -> timeout <= 1, go to DONE.
REQ-026 DONE: done=1; all status outputs hold; no comparison; start=1 -> behaves as IDLE start (REQ-019).
REQ-027 start in CHECK SHALL be ignored.
REQ-028 Wrap and timeout on same edge: wrap counted, timeout=0, DONE.
REQ-029 WIDTH=1 SHALL be supported; every enabled cycle with expected=1 is a wrap.
REQ-030 Outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 at a clk edge SHALL force IDLE, expected=0, err=0, err_count=0, wrap_count=0, timeout=0, done=0, pass=0, stall counter=0.
REQ-032 rst SHALL take priority over start and all checks, including mid-CHECK; no status from the aborted run survives.

Verification (WIDTH=4, WRAPS_TO_PASS=1, TIMEOUT=8 unless noted)
REQ-033 Good counter from 0, enb=1 continuous, start at count=0 -> DONE 16 cycles after start, pass=1, err_count=0, wrap_count=1.
REQ-034 Counter skips 5->7 once -> err=1, err_count=1, expected resyncs to 8 next cycle, later DONE with pass=0.
REQ-035 carryout stuck 0 -> err_count=1 at wrap cycle, wrap_count stays 0, run ends by timeout when enb dropped, pass=0.
REQ-036 enb=0 for 8 consecutive cycles in CHECK -> timeout=1, done=1, pass=0; 7 cycles then enb=1 -> no timeout.
REQ-037 rst pulse mid-CHECK at err_count=3 -> next cycle all status 0, state IDLE; start again re-checks cleanly.
REQ-038 WRAPS_TO_PASS=3, enb toggled randomly -> DONE only after 3rd wrap, pass=1; start in CHECK has no effect.
